// File: rtl/acc_monitor_tx_pkg.sv
// Shared definitions for the accumulator-monitor UART transmitter:
// default parameters, TX FSM encoding and the FIFO occupancy helper.
package acc_monitor_tx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 32'd4;
  localparam int unsigned FIFO_DEPTH_DEF   = 32'd4;
  localparam int unsigned DATA_W           = 32'd8;
  localparam int unsigned COUNT_W          = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Occupancy after one cycle; push and pop together leave it unchanged.
  function automatic logic [COUNT_W-1:0] count_step(input logic [COUNT_W-1:0] cnt,
                                                    input logic inc,
                                                    input logic dec);
    logic [COUNT_W-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 5'd1;
    end else if (dec && !inc) begin
      res = cnt - 5'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_monitor_tx_if.sv
// Bus bundle between the datapath (master) and the monitor transmitter (slave).
interface acc_monitor_tx_if;
  logic [7:0] fpga_data;
  logic       enable;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_count;

  modport master (
    output fpga_data, enable,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  fpga_data, enable,
    output tx, busy, overflow, fifo_count
  );
endinterface

// File: rtl/acc_monitor_tx_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; a push while full is taken only
// when a pop frees the head slot in the same cycle.
module sync_fifo
  import acc_monitor_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [WIDTH-1:0]   data_in_i,
  output logic [WIDTH-1:0]   data_out_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               full_o
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               do_push_s;
  logic               do_pop_s;

  assign full_o     = (count_q == COUNT_W'(DEPTH));
  assign count_o    = count_q;
  assign data_out_o = mem_q[rd_ptr_q];

  // Qualify requests against current occupancy.
  always_comb begin
    do_pop_s  = pop_i && (count_q != 5'd0);
    do_push_s = push_i && (!full_o || do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_step(count_q, do_push_s, do_pop_s);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

endmodule

// File: rtl/acc_monitor_tx.sv
// Accumulator change monitor: queues every new value of fpga_data and sends
// each one out as an 8N1 UART frame, LSB first.
module acc_monitor_tx
  import acc_monitor_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  acc_monitor_tx_if.slave bus
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 32'd1);

  tx_state_e          state_q;
  logic [15:0]        cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               tx_q;
  logic               busy_q;
  logic               overflow_q;
  logic [7:0]         last_val_q;

  logic               push_req_s;
  logic               push_acc_s;
  logic               pop_s;
  logic               full_s;
  logic               bit_end_s;
  logic               nxt_idle_s;
  logic [7:0]         head_s;
  logic [COUNT_W-1:0] count_s;
  logic [COUNT_W-1:0] count_nxt_s;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_acc_s),
    .pop_i      (pop_s),
    .data_in_i  (bus.fpga_data),
    .data_out_o (head_s),
    .count_o    (count_s),
    .full_o     (full_s)
  );

  // Change detection, FIFO handshake and look-ahead for the busy flop.
  always_comb begin
    push_req_s  = bus.enable && (bus.fpga_data != last_val_q);
    pop_s       = (state_q == ST_IDLE) && (count_s != 5'd0);
    push_acc_s  = push_req_s && (!full_s || pop_s);
    bit_end_s   = (cnt_q == BIT_LAST);
    count_nxt_s = count_step(count_s, push_acc_s, pop_s);
    nxt_idle_s  = ((state_q == ST_IDLE) && !pop_s) ||
                  ((state_q == ST_STOP) && bit_end_s);
  end

  // Last seen value and sticky drop flag; last_val moves even on a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_val_q <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (push_req_s) begin
        last_val_q <= bus.fpga_data;
      end
      if (push_req_s && !push_acc_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // TX FSM; tx_q is loaded with the level of the upcoming state/bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= !nxt_idle_s || (count_nxt_s != 5'd0);
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            shift_q <= head_s;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            cnt_q   <= 16'd0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            cnt_q <= 16'd0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          tx_q <= 1'b1;
          if (bit_end_s) begin
            cnt_q   <= 16'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          cnt_q   <= 16'd0;
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_s;

endmodule

// File: tb/tb_acc_monitor_tx.sv
// Directed bench for acc_monitor_tx: a frame-timeline model checked every
// cycle, a UART line decoder, and literal expectations per scenario.
module tb_acc_monitor_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  acc_monitor_tx_if bus_if();

  acc_monitor_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: queue of pending bytes plus a frame timeline
  logic [7:0] mq[$];
  logic [7:0] m_last;
  logic [7:0] m_cur;
  bit         m_ovf;
  bit         m_in_frame;
  int         m_t;
  bit         m_req;
  bit         m_pop;
  bit         m_acc;
  int         m_sz;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_last     = 8'h00;
      m_ovf      = 1'b0;
      m_in_frame = 1'b0;
      m_t        = 0;
    end else begin
      m_sz  = mq.size();
      m_req = bus_if.enable && (bus_if.fpga_data != m_last);
      m_pop = !m_in_frame && (m_sz > 0);
      m_acc = m_req && ((m_sz < DEPTH) || m_pop);
      if (m_in_frame) begin
        if (m_t == FRAME - 1) m_in_frame = 1'b0;
        else m_t++;
      end
      if (m_pop) begin
        m_cur      = mq.pop_front();
        m_in_frame = 1'b1;
        m_t        = 0;
      end
      if (m_req) m_last = bus_if.fpga_data;
      if (m_acc) mq.push_back(bus_if.fpga_data);
      else if (m_req) m_ovf = 1'b1;
    end
  end

  // per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_tx", {31'd0, bus_if.tx},
            {31'd0, (m_in_frame ? frame_bit(m_cur, m_t / CPB) : 1'b1)});
      check("cyc_busy", {31'd0, bus_if.busy}, {31'd0, (m_in_frame || (mq.size() != 0))});
      check("cyc_overflow", {31'd0, bus_if.overflow}, {31'd0, m_ovf});
      check("cyc_fifo_count", {27'd0, bus_if.fifo_count}, 32'(mq.size()));
    end
  end

  // ---------------- UART line decoder
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] dec_b;
  bit         rst_seen;

  always @(posedge rst) rst_seen = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus_if.tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          dec_b[i] = bus_if.tx;
        end
        repeat (CPB) @(negedge clk);
        if (!rst_seen) begin
          check("stop_bit", {31'd0, bus_if.tx}, 32'd1);
          rx_q.push_back(dec_b);
        end
      end
    end
  end

  task automatic check_rx();
    int n;
    check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus helpers
  task automatic step(input logic [7:0] d);
    bus_if.fpga_data = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.fpga_data = 8'h00;
    bus_if.enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus_if.busy) begin
        done = 1'b1;
        break;
      end
    end
    check("wait_idle", {31'd0, done}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int frame_len;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus_if.fpga_data = 8'h00;
    bus_if.enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state and no push against last_val=00
    check("rst_tx", {31'd0, bus_if.tx}, 32'd1);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    check("rst_fifo_count", {27'd0, bus_if.fifo_count}, 32'd0);

    // single byte A5: pushed at edge k, tx low after edge k+1, 40-cycle frame
    step(8'hA5);
    check("a5_count_after_push", {27'd0, bus_if.fifo_count}, 32'd1);
    check("a5_tx_still_high", {31'd0, bus_if.tx}, 32'd1);
    @(negedge clk);
    check("a5_tx_low", {31'd0, bus_if.tx}, 32'd0);
    check("a5_busy", {31'd0, bus_if.busy}, 32'd1);
    frame_len = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.busy) frame_len++;
      else break;
    end
    check("a5_frame_len", 32'(frame_len), 32'd40);
    wait_idle(100);
    exp_q = '{8'hA5};
    check_rx();

    // burst 11..55, then a new change lands on the pop cycle of a full FIFO
    do_reset();
    step(8'h11); step(8'h22); step(8'h33); step(8'h44); step(8'h55);
    check("burst_count", {27'd0, bus_if.fifo_count}, 32'd4);
    check("burst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    repeat (37) @(negedge clk);
    check("fullpop_count_before", {27'd0, bus_if.fifo_count}, 32'd4);
    step(8'h66);
    check("fullpop_count", {27'd0, bus_if.fifo_count}, 32'd4);
    check("fullpop_overflow", {31'd0, bus_if.overflow}, 32'd0);
    wait_idle(400);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    check_rx();

    // overflow: six changes in six cycles, the sixth is dropped
    do_reset();
    step(8'h01); step(8'h02); step(8'h03); step(8'h04); step(8'h05); step(8'h06);
    check("ovf_flag", {31'd0, bus_if.overflow}, 32'd1);
    check("ovf_count", {27'd0, bus_if.fifo_count}, 32'd4);
    wait_idle(400);
    check("ovf_sticky", {31'd0, bus_if.overflow}, 32'd1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx();

    // stable value gives one frame; a disabled change is not pushed
    do_reset();
    step(8'h3C);
    repeat (100) @(negedge clk);
    wait_idle(100);
    bus_if.enable = 1'b0;
    step(8'h7E);
    check("dis_count", {27'd0, bus_if.fifo_count}, 32'd0);
    check("dis_busy", {31'd0, bus_if.busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("dis_tx", {31'd0, bus_if.tx}, 32'd1);
    bus_if.enable = 1'b1;
    @(negedge clk);
    check("reen_count", {27'd0, bus_if.fifo_count}, 32'd1);
    wait_idle(100);
    exp_q = '{8'h3C, 8'h7E};
    check_rx();

    // reset during DATA bit 3 of 0x96 with 0x69 queued
    do_reset();
    step(8'h96);
    step(8'h69);
    repeat (17) @(negedge clk);
    check("mid_tx_bit3", {31'd0, bus_if.tx}, 32'd0);
    check("mid_count", {27'd0, bus_if.fifo_count}, 32'd1);
    #1 rst = 1'b1;
    bus_if.fpga_data = 8'h00;
    #1;
    check("mid_rst_tx", {31'd0, bus_if.tx}, 32'd1);
    check("mid_rst_count", {27'd0, bus_if.fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("post_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("post_rst_tx", {31'd0, bus_if.tx}, 32'd1);
    exp_q.delete();
    check_rx();
    step(8'h5A);
    wait_idle(100);
    exp_q = '{8'h5A};
    check_rx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_monitor_tx.md
ACC_MONITOR_TX -- requirements
Module: acc_monitor_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, capture FIFO entries; power of two, 2..16.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port fpga_data  input  8  accumulator value registered by the datapath each cycle.
REQ-006 Port enable  input  1  capture enable; low suppresses change detection only.
REQ-007 Port tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 Port busy  output  1  high while a frame is in flight or the FIFO is non-empty.
REQ-009 Port overflow  output  1  sticky flag; a change was dropped because the FIFO was full.
REQ-010 Port fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-011 Block SHALL hold last_val (8 bits, reset 8'h00) as the last change-detected value.
REQ-012 At each edge with enable=1 and fpga_data != last_val, block SHALL load last_val with fpga_data and raise a push request.
REQ-013 With enable=0, block SHALL neither update last_val nor push.
REQ-014 Push SHALL be accepted when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-015 A rejected push SHALL be dropped, last_val still updated, and overflow set until reset.
REQ-016 FIFO SHALL be first-in first-out, with pointers wrapping modulo FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; when fifo_count != 0, pop the head into an 8-bit shift register, clear the bit counter and enter START.
REQ-019 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-020 DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after the 8th bit enter STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle (the pop cycle).
REQ-023 Latency: a change sampled at edge k is pushed at edge k; if the FIFO was empty and the FSM was in IDLE, the pop SHALL occur at edge k+1 and tx SHALL go low after edge k+1.
REQ-024 tx SHALL be driven directly from a flop (glitch-free).
REQ-025 busy SHALL equal (state != IDLE) OR (fifo_count != 0), registered-output consistent.
REQ-026 Bit-period counter width SHALL be 16 bits; the counter SHALL reload to 0 at every bit boundary.
REQ-027 Changes of enable SHALL NOT affect a frame already in flight or entries already queued.

Reset
REQ-028 rst=1 SHALL immediately force tx=1, busy=0, overflow=0, fifo_count=0, state=IDLE and last_val=8'h00, independent of clk.
REQ-029 Reset mid-frame SHALL abandon the frame; no partial frame SHALL resume after release.
REQ-030 The first edge after rst falls SHALL perform normal change detection against last_val=8'h00.

Structure
REQ-031 FSM state encodings and default parameter values SHALL live in the shared CPU definitions include, not in the module.
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width (8) and depth, exposing push, pop, data_in, data_out, count and full.
REQ-033 Change detection, the TX FSM and the bit counters SHALL reside in acc_monitor_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single byte: fpga_data 00->A5 with enable=1 -> tx low 2 cycles later; decoded bits 1,0,1,0,0,1,0,1; stop bit high; frame 40 cycles.
REQ-035 Burst: 11,22,33,44,55 on consecutive cycles while idle -> 11 sent immediately, 22..55 queued, no overflow; five frames with 1-cycle gaps.
REQ-036 Overflow: six distinct values in six cycles -> sixth dropped, overflow=1 and stays high; transmitted sequence omits the dropped value.
REQ-037 Stable and disabled: fpga_data held at 3C for 100 cycles -> one frame only; with enable=0, change 3C->7E -> no push.
REQ-038 Reset mid-frame: assert rst in DATA bit 3 -> tx=1 the same cycle, fifo_count=0; after release, 00->5A -> clean frame 5A.
REQ-039 Full plus pop: FIFO full while FSM pops in the same cycle as a new change -> push accepted, fifo_count stays 4, overflow=0.
